// File: rtl/mult_job_sequencer_pkg.sv
// mult_job_sequencer_pkg: shared FSM state encodings and result-buffer depth default (package mult_defs)
package mult_defs;
    localparam int FIFO_DEPTH_DEF = 2;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_PUSH  = 2'd3
    } state_t;
endpackage

// File: rtl/mult_job_sequencer_if.sv
// mult_job_sequencer_if: operand input, multiplier and result output handshakes of the job sequencer
interface mult_job_sequencer_if #(parameter int N = 4);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_a;
    logic [N-1:0]   in_b;
    logic           mult_st;
    logic [N-1:0]   mult_a;
    logic [N-1:0]   mult_b;
    logic           mult_done;
    logic [2*N-1:0] mult_prod;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_prod;
    modport slave (
        input  in_valid, in_a, in_b, mult_done, mult_prod, out_ready,
        output in_ready, mult_st, mult_a, mult_b, out_valid, out_prod
    );
    modport master (
        output in_valid, in_a, in_b, mult_done, mult_prod, out_ready,
        input  in_ready, mult_st, mult_a, mult_b, out_valid, out_prod
    );
endinterface

// File: rtl/mult_job_sequencer_prod_fifo.sv
// prod_fifo: small result buffer with wrapping pointers and an occupancy count
module prod_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign dout = mem[rp];
    // write at tail, read from head; push and pop together keep the count
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= inc(wp);
            end
            if (pop) rp <= inc(rp);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer: feeds operand pairs to an external multiplier one job at a time and buffers products; MULT_ZERO_BYPASS_EN skips the multiplier for zero operands
import mult_defs::*;
module mult_job_sequencer #(
    parameter int N          = 4,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_job_sequencer_if.slave  bus,
    output logic                 busy
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    state_t         state;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic [2*N-1:0] hold;
    logic           st_q;
    logic [CW-1:0]  fifo_count;
    logic           accept;
    assign bus.in_ready  = !rst && (state == S_IDLE) && (fifo_count < CW'(FIFO_DEPTH));
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.mult_st   = st_q;
    assign bus.mult_a    = op_a;
    assign bus.mult_b    = op_b;
    assign bus.out_valid = (fifo_count != '0);
    assign busy          = (state != S_IDLE);
    // job FSM: accept, start pulse, wait for done, push product
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            hold  <= '0;
            st_q  <= 1'b0;
        end else begin
            st_q <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    op_a <= bus.in_a;
                    op_b <= bus.in_b;
`ifdef MULT_ZERO_BYPASS_EN
                    if (bus.in_a == '0 || bus.in_b == '0) begin
                        hold  <= '0;
                        state <= S_PUSH;
                    end else begin
                        st_q  <= 1'b1;
                        state <= S_START;
                    end
`else
                    st_q  <= 1'b1;
                    state <= S_START;
`endif
                end
                S_START: state <= S_WAIT;
                S_WAIT: if (bus.mult_done) begin
                    hold  <= bus.mult_prod;
                    state <= S_PUSH;
                end
                S_PUSH: state <= S_IDLE;
            endcase
        end
    end
    prod_fifo #(.W(2*N), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (state == S_PUSH),
        .pop   (bus.out_valid && bus.out_ready),
        .din   (hold),
        .dout  (bus.out_prod),
        .count (fifo_count)
    );
endmodule
